// File: rtl/regfile_write_arbiter.sv
// Purpose : owns the register_file write port; clears all registers after
//           reset, then shares the port between requesters A and B round-robin.
// Latency : handshake edge to regWrite high is 1 cycle; 1 write per cycle.
// Backpr. : reqX_ready is combinational; an ungranted request simply waits,
//           both readys are held low while the clear sequence runs.
//
// Ports:
//   CLK, RST                         clock (rising edge), async active-low reset
//   reqA_valid/dest/data, reqA_ready requester A handshake
//   reqB_valid/dest/data, reqB_ready requester B handshake
//   destReg, writeData, regWrite     registered write port to register_file
//   initDone                         clear sequence complete, arbitration live
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8    // must equal 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  reqA_valid,
  input  logic [ADDR_WIDTH-1:0] reqA_dest,
  input  logic [DATA_WIDTH-1:0] reqA_data,
  output logic                  reqA_ready,
  input  logic                  reqB_valid,
  input  logic [ADDR_WIDTH-1:0] reqB_dest,
  input  logic [DATA_WIDTH-1:0] reqB_data,
  output logic                  reqB_ready,
  output logic [ADDR_WIDTH-1:0] destReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWrite,
  output logic                  initDone
);

  // One-hot style codes so that both 2'b00 and 2'b11 are illegal and recover.
  typedef enum logic [1:0] {
    INIT = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam logic                  PRI_A    = 1'b0;
  localparam logic                  PRI_B    = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  pri;   // requester that wins the next contention

  logic inRun;
  assign inRun = (state == RUN);

  // Grants depend only on state, priority and the valids, never on dest/data.
  assign reqA_ready = inRun & reqA_valid & (~reqB_valid | (pri == PRI_A));
  assign reqB_ready = inRun & reqB_valid & (~reqA_valid | (pri == PRI_B));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= INIT;
      cnt       <= '0;
      pri       <= PRI_A;
      regWrite  <= 1'b0;
      destReg   <= '0;
      writeData <= '0;
      initDone  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          // Clear one register per cycle; the last clear also opens arbitration.
          regWrite  <= 1'b1;
          destReg   <= cnt;
          writeData <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_REG) begin
            state    <= RUN;
            initDone <= 1'b1;
          end
        end
        RUN: begin
          if (reqA_ready) begin
            regWrite  <= 1'b1;
            destReg   <= reqA_dest;
            writeData <= reqA_data;
            pri       <= PRI_B;
          end else if (reqB_ready) begin
            regWrite  <= 1'b1;
            destReg   <= reqB_dest;
            writeData <= reqB_data;
            pri       <= PRI_A;
          end else begin
            // Idle: address and data hold their last values.
            regWrite <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          pri       <= PRI_A;
          regWrite  <= 1'b0;
          initDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule
